snax_tcdm_responder: RTL



---
 rtl/snax_tcdm_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/snax_tcdm_responder.sv
// Banked TCDM responder for the SNAX accelerator-side request ports.
// Requests from NumPorts initiators are decoded to a word-interleaved bank,
// arbitrated round-robin per bank, and served from an internal SRAM array.
// Every granted request is answered with exactly one p_valid pulse one cycle
// after its grant; writes answer with zero data, reads and AMOs with the word.

package snax_tcdm_responder_pkg;

  localparam int unsigned TcdmAddrWidth = 17;
  localparam int unsigned TcdmDataWidth = 64;
  localparam int unsigned TcdmStrbWidth = TcdmDataWidth / 8;
  localparam int unsigned TcdmUserWidth = 1;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0] addr;
    logic                     write;
    amo_op_e                  amo;
    logic [TcdmDataWidth-1:0] data;
    logic [TcdmStrbWidth-1:0] strb;
    logic [TcdmUserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    tcdm_rsp_chan_t p;
    logic           p_valid;
    logic           q_ready;
  } tcdm_rsp_t;

endpackage

module snax_tcdm_responder
  import snax_tcdm_responder_pkg::*;
#(
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 17,
  parameter int unsigned NumBanks  = 32,
  parameter int unsigned BankWords = 256,
  parameter type tcdm_req_t = snax_tcdm_responder_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = snax_tcdm_responder_pkg::tcdm_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  tcdm_req_t [NumPorts-1:0] tcdm_req_i,
  output tcdm_rsp_t [NumPorts-1:0] tcdm_rsp_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth  = (StrbWidth > 1) ? $clog2(StrbWidth) : 1;
  localparam int unsigned BankSel   = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned RowSel    = (BankWords > 1) ? $clog2(BankWords) : 1;
  localparam int unsigned PortSel   = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  // Per-port decode
  logic [AddrWidth-1:0] port_addr [NumPorts];
  logic [BankSel-1:0]   port_bank [NumPorts];
  logic [RowSel-1:0]    port_row  [NumPorts];
  logic [NumPorts-1:0]  port_we;
  logic [NumPorts-1:0]  port_rd;
  logic [NumPorts-1:0]  unused_bits;

  // Per-bank arbitration
  logic [PortSel-1:0]   rr_ptr_q  [NumBanks];
  logic [NumBanks-1:0]  bank_gnt;
  logic [PortSel-1:0]   bank_idx  [NumBanks];
  logic [NumPorts-1:0]  port_gnt;

  // Per-bank write channel
  logic [NumBanks-1:0]  bank_we;
  logic [RowSel-1:0]    bank_row   [NumBanks];
  logic [DataWidth-1:0] bank_wdata [NumBanks];
  logic [StrbWidth-1:0] bank_strb  [NumBanks];

  // Storage and response registers
  logic [DataWidth-1:0] mem_q [NumBanks][BankWords];
  logic [NumPorts-1:0]  rsp_valid_q;
  logic [DataWidth-1:0] rsp_data_q [NumPorts];

  // Split each address into bank and row; upper bits wrap the capacity.
  // AMOs are served as plain reads, so only AMONone writes modify memory.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      port_addr[i]   = tcdm_req_i[i].q.addr;
      port_bank[i]   = port_addr[i][OffWidth +: BankSel];
      port_row[i]    = port_addr[i][OffWidth + BankSel +: RowSel];
      port_we[i]     = tcdm_req_i[i].q.write && (tcdm_req_i[i].q.amo == AMONone);
      port_rd[i]     = !port_we[i];
      unused_bits[i] = ^{tcdm_req_i[i].q.user, port_addr[i]};
    end
  end

  // Round-robin search per bank: first requesting port at or after the pointer.
  // Grants are suppressed while reset is asserted so q_ready reads 0.
  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      bank_gnt[b] = 1'b0;
      bank_idx[b] = '0;
      for (int k = 0; k < NumPorts; k++) begin
        int unsigned cand;
        cand = int'(rr_ptr_q[b]) + k;
        if (cand >= NumPorts) cand = cand - NumPorts;
        if (!bank_gnt[b] && rst_ni && tcdm_req_i[cand].q_valid &&
            (port_bank[cand] == BankSel'(b))) begin
          bank_gnt[b] = 1'b1;
          bank_idx[b] = PortSel'(cand);
        end
      end
    end
  end

  // A port is ready when the bank it addresses picked it.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      port_gnt[i] = bank_gnt[port_bank[i]] && (bank_idx[port_bank[i]] == PortSel'(i));
    end
  end

  // Advance each bank pointer past the port it just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++) rr_ptr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (bank_gnt[b]) begin
          rr_ptr_q[b] <= (bank_idx[b] == PortSel'(NumPorts - 1)) ? '0 : bank_idx[b] + 1'b1;
        end
      end
    end
  end

  // Route the granted port's write fields to its bank.
  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      bank_we[b]    = bank_gnt[b] && port_we[bank_idx[b]];
      bank_row[b]   = port_row[bank_idx[b]];
      bank_wdata[b] = tcdm_req_i[bank_idx[b]].q.data;
      bank_strb[b]  = tcdm_req_i[bank_idx[b]].q.strb;
    end
  end

  // Byte-strobed SRAM write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_we[b]) begin
        for (int j = 0; j < StrbWidth; j++) begin
          if (bank_strb[b][j]) begin
            mem_q[b][bank_row[b]][j*8 +: 8] <= bank_wdata[b][j*8 +: 8];
          end
        end
      end
    end
  end

  // Register one response per grant; read data is the pre-edge word, writes return 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < NumPorts; i++) rsp_data_q[i] <= '0;
    end else begin
      rsp_valid_q <= port_gnt;
      for (int i = 0; i < NumPorts; i++) begin
        rsp_data_q[i] <= (port_gnt[i] && port_rd[i]) ? mem_q[port_bank[i]][port_row[i]] : '0;
      end
    end
  end

  // Pack grants and registered responses onto the response structs.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      tcdm_rsp_o[i]         = '0;
      tcdm_rsp_o[i].q_ready = port_gnt[i];
      tcdm_rsp_o[i].p_valid = rsp_valid_q[i];
      tcdm_rsp_o[i].p.data  = rsp_data_q[i];
    end
  end

endmodule
